ahb_slave_mux_system: RTL and testbench
=======================================

# ahb_slave_mux_system

Data-phase response multiplexer with an integrated default slave for the Cortex-M3 system AHB-Lite bus. It takes the address-phase HSEL lines from the system address decoder and registers them into a data-phase select. It then steers HRDATA, HREADY and HRESP from the RAM slave, the APB bridge or its own default slave back to the bus master. The default slave answers every access outside the decoded regions with the standard two-cycle AHB ERROR response.

## Interface
Parameters:
- none; data width fixed at 32 bits.

Ports:
- HCLK  in  1  system bus clock. One clock; all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL_RAM  in  1  address-phase select, RAM slave.
- HSEL_APB  in  1  address-phase select, APB bridge.
- HSEL_DefSlave  in  1  address-phase select, internal default slave.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HADDR  in  32  address-phase address (error capture only).
- HREADY  in  1  bus HREADY fed back (same net as HREADY output, after the system interconnect).
- HRDATA_RAM  in  32  RAM slave read data.
- HREADYOUT_RAM  in  1  RAM slave ready.
- HRESP_RAM  in  1  RAM slave response.
- HRDATA_APB  in  32  APB bridge read data.
- HREADYOUT_APB  in  1  APB bridge ready.
- HRESP_APB  in  1  APB bridge response.
- HRDATA_MUX  out  32  read data to master.
- HREADY_MUX  out  1  ready to master (drives the bus HREADY).
- HRESP_MUX  out  1  response to master; 0=OKAY, 1=ERROR.
- ERR_CLR  in  1  clears captured error (error capture only).
- ERR_VALID  out  1  sticky flag: a default-slave error was captured.
- ERR_ADDR  out  32  address of the first captured default-slave error.

## Operation
Data-phase select:
- `sel_q[2:0]` is one-hot {Def, APB, RAM}.
- It loads {HSEL_DefSlave, HSEL_APB, HSEL_RAM} on each edge where HREADY=1, and holds otherwise.
- Reset value 3'b100 (default slave).
- The output mux follows `sel_q`:
  - RAM selected: HRDATA_MUX, HREADY_MUX and HRESP_MUX come from the RAM slave ports.
  - APB selected: outputs come from the APB bridge ports.
  - Def selected: outputs come from the default slave; HRDATA_MUX = 0.
- Non-one-hot `sel_q` (decoder fault) is treated as Def.

Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
- An access is "accepted" when HSEL_DefSlave & HTRANS[1] & HREADY.
- DS_IDLE: outputs HREADYOUT=1, HRESP=0. Goes to DS_ERR1 on an accepted access, else stays.
- DS_ERR1: outputs HREADYOUT=0, HRESP=1. Always goes to DS_ERR2.
- DS_ERR2: outputs HREADYOUT=1, HRESP=1. Goes to DS_ERR1 on an accepted access, else to DS_IDLE.
- IDLE or BUSY transfers to the default slave get a zero-wait OKAY.

Error capture:
- On an accepted access while ERR_VALID=0, HADDR is registered into ERR_ADDR and ERR_VALID sets on the same edge.
- Later errors do not overwrite ERR_ADDR until it is cleared.
- ERR_CLR=1 clears ERR_VALID; ERR_ADDR holds its value.
- Simultaneous ERR_CLR and an accepted access: the capture wins. ERR_ADDR takes the new HADDR and ERR_VALID stays 1.

## Timing
- Reset values:
  - `sel_q`=3'b100, FSM=DS_IDLE.
  - HREADY_MUX=1, HRESP_MUX=0, HRDATA_MUX=0.
  - ERR_VALID=0, ERR_ADDR=0.
- Output mux is combinational from `sel_q` and the slave inputs; no added latency.
- Default slave error: two data-phase cycles.
  - First cycle: HREADY_MUX=0, HRESP_MUX=1.
  - Second cycle: HREADY_MUX=1, HRESP_MUX=1.
- The select is not updated during slave wait states (HREADY=0), so a stalled data phase keeps its source.
- Reset mid-transfer returns all state to reset values immediately (asynchronous); the aborted transfer is not completed.

## Configuration
- Macro `AHB_SLAVEMUX_ERRCAPT_EN`.
- Defined: error-capture logic as described above.
- Undefined: capture registers are removed. ERR_VALID=0 and ERR_ADDR=32'h0 constantly, and ERR_CLR is ignored. Mux and default-slave behaviour are unchanged.

## Test plan
- Reset: assert HRESETn=0 mid-traffic → HREADY_MUX=1, HRESP_MUX=0, HRDATA_MUX=0, ERR_VALID=0 with no clock edge required.
- RAM read with one wait state:
  - Stimulus: NONSEQ to 0x2000_0010 with HSEL_RAM=1; RAM returns HREADYOUT_RAM=0 then 1 with HRDATA_RAM=0xCAFE_F00D.
  - Response: HREADY_MUX = 0 then 1, HRDATA_MUX=0xCAFE_F00D, HRESP_MUX=0.
- Unmapped access:
  - Stimulus: NONSEQ to 0x6000_0000 (HSEL_DefSlave=1).
  - Response: data phase shows HREADY_MUX/HRESP_MUX = 0/1 then 1/1; ERR_VALID=1 and ERR_ADDR=0x6000_0000 next edge.
- Back-to-back errors:
  - Stimulus: NONSEQ to 0x6000_0000 then 0x7000_0004, the second accepted in DS_ERR2.
  - Response: two consecutive 0/1, 1/1 pairs; ERR_ADDR stays 0x6000_0000.
- APB error passthrough:
  - Stimulus: HSEL_APB access, bridge returns HRESP_APB=1, HREADYOUT_APB 0 then 1.
  - Response: identical sequence on the mux outputs; ERR_VALID unchanged.
- Clear vs capture:
  - Stimulus: ERR_CLR=1 alone.
  - Response: ERR_VALID=0.
  - Stimulus: ERR_CLR=1 on the same edge as an access to 0x8000_0000.
  - Response: ERR_VALID=1, ERR_ADDR=0x8000_0000. With the macro undefined, ERR_VALID stays 0 throughout.

Source files
------------

// File: rtl/ahb_slave_mux_system.sv
// AHB-Lite data-phase response mux with integrated default slave (two-cycle ERROR).
// Optional error-address capture is built when AHB_SLAVEMUX_ERRCAPT_EN is defined.
module ahb_slave_mux_system (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL_RAM,
  input  logic        HSEL_APB,
  input  logic        HSEL_DefSlave,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HREADY,
  input  logic [31:0] HRDATA_RAM,
  input  logic        HREADYOUT_RAM,
  input  logic        HRESP_RAM,
  input  logic [31:0] HRDATA_APB,
  input  logic        HREADYOUT_APB,
  input  logic        HRESP_APB,
  output logic [31:0] HRDATA_MUX,
  output logic        HREADY_MUX,
  output logic        HRESP_MUX,
  input  logic        ERR_CLR,
  output logic        ERR_VALID,
  output logic [31:0] ERR_ADDR
);

  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_t;

  logic [2:0] sel_q;
  ds_state_t  ds_state, ds_next;
  logic       ds_ready, ds_resp;
  logic       accepted;

  assign accepted = HSEL_DefSlave & HTRANS[1] & HREADY;

  // One-hot {Def, APB, RAM}; frozen while the current data phase is stalled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= 3'b100;
    end else if (HREADY) begin
      sel_q <= {HSEL_DefSlave, HSEL_APB, HSEL_RAM};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_state <= DS_IDLE;
    end else begin
      ds_state <= ds_next;
    end
  end

  always_comb begin
    ds_next = DS_IDLE;
    case (ds_state)
      DS_IDLE: ds_next = accepted ? DS_ERR1 : DS_IDLE;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = accepted ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    case (ds_state)
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
      end
      DS_ERR2: begin
        ds_ready = 1'b1;
        ds_resp  = 1'b1;
      end
      default: begin
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
      end
    endcase
  end

  // Anything other than a clean RAM/APB one-hot falls back to the default slave.
  always_comb begin
    HRDATA_MUX = 32'h0;
    HREADY_MUX = ds_ready;
    HRESP_MUX  = ds_resp;
    case (sel_q)
      3'b001: begin
        HRDATA_MUX = HRDATA_RAM;
        HREADY_MUX = HREADYOUT_RAM;
        HRESP_MUX  = HRESP_RAM;
      end
      3'b010: begin
        HRDATA_MUX = HRDATA_APB;
        HREADY_MUX = HREADYOUT_APB;
        HRESP_MUX  = HRESP_APB;
      end
      default: begin
        HRDATA_MUX = 32'h0;
        HREADY_MUX = ds_ready;
        HRESP_MUX  = ds_resp;
      end
    endcase
  end

`ifdef AHB_SLAVEMUX_ERRCAPT_EN
  logic        err_valid_q;
  logic [31:0] err_addr_q;

  // A new capture beats a simultaneous clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0;
    end else if (accepted && (!err_valid_q || ERR_CLR)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= HADDR;
    end else if (ERR_CLR) begin
      err_valid_q <= 1'b0;
    end
  end

  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;

  logic unused_sig;
  assign unused_sig = HTRANS[0];
`else
  assign ERR_VALID = 1'b0;
  assign ERR_ADDR  = 32'h0;

  logic unused_sig;
  assign unused_sig = ^{HTRANS[0], HADDR, ERR_CLR};
`endif

endmodule

// File: tb/tb_ahb_slave_mux_system.sv
// Scoreboard bench for ahb_slave_mux_system; expectations follow AHB_SLAVEMUX_ERRCAPT_EN.
module tb_ahb_slave_mux_system;

`ifdef AHB_SLAVEMUX_ERRCAPT_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL_RAM, HSEL_APB, HSEL_DefSlave;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HREADY;
  logic [31:0] HRDATA_RAM, HRDATA_APB;
  logic        HREADYOUT_RAM, HRESP_RAM, HREADYOUT_APB, HRESP_APB;
  logic [31:0] HRDATA_MUX;
  logic        HREADY_MUX, HRESP_MUX;
  logic        ERR_CLR;
  logic        ERR_VALID;
  logic [31:0] ERR_ADDR;

  assign HREADY = HREADY_MUX;

  ahb_slave_mux_system dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_RAM(HSEL_RAM), .HSEL_APB(HSEL_APB), .HSEL_DefSlave(HSEL_DefSlave),
    .HTRANS(HTRANS), .HADDR(HADDR), .HREADY(HREADY),
    .HRDATA_RAM(HRDATA_RAM), .HREADYOUT_RAM(HREADYOUT_RAM), .HRESP_RAM(HRESP_RAM),
    .HRDATA_APB(HRDATA_APB), .HREADYOUT_APB(HREADYOUT_APB), .HRESP_APB(HRESP_APB),
    .HRDATA_MUX(HRDATA_MUX), .HREADY_MUX(HREADY_MUX), .HRESP_MUX(HRESP_MUX),
    .ERR_CLR(ERR_CLR), .ERR_VALID(ERR_VALID), .ERR_ADDR(ERR_ADDR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        ev;
    logic [31:0] ea;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Capture-dependent fields collapse to zero when the capture logic is not built.
  task automatic push(input logic rdy, input logic resp, input logic [31:0] data,
                      input logic ev, input logic [31:0] ea);
    exp_t e;
    e.rdy  = rdy;
    e.resp = resp;
    e.data = data;
    e.ev   = CAP ? ev : 1'b0;
    e.ea   = CAP ? ea : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic compare_head(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d_hready", name, cyc), {31'd0, HREADY_MUX}, {31'd0, e.rdy});
      check($sformatf("%s_c%0d_hresp", name, cyc), {31'd0, HRESP_MUX}, {31'd0, e.resp});
      check($sformatf("%s_c%0d_hrdata", name, cyc), HRDATA_MUX, e.data);
      check($sformatf("%s_c%0d_err_valid", name, cyc), {31'd0, ERR_VALID}, {31'd0, e.ev});
      check($sformatf("%s_c%0d_err_addr", name, cyc), ERR_ADDR, e.ea);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string name, input logic rdy, input logic resp,
                      input logic [31:0] data, input logic ev, input logic [31:0] ea);
    push(rdy, resp, data, ev, ea);
    @(negedge HCLK);
    compare_head(name);
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic addr_phase(input logic s_ram, input logic s_apb, input logic s_def,
                            input logic [1:0] trans, input logic [31:0] addr);
    HSEL_RAM      = s_ram;
    HSEL_APB      = s_apb;
    HSEL_DefSlave = s_def;
    HTRANS        = trans;
    HADDR         = addr;
  endtask

  initial begin
    HRESETn = 1'b0;
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    HRDATA_RAM = 32'h1111_1111; HREADYOUT_RAM = 1'b1; HRESP_RAM = 1'b0;
    HRDATA_APB = 32'h2222_2222; HREADYOUT_APB = 1'b1; HRESP_APB = 1'b0;
    ERR_CLR = 1'b0;
    #3;
    push(1, 0, 32'h0, 0, 32'h0);
    compare_head("reset");
    #9;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // RAM read, one wait state
    addr_phase(1, 0, 0, 2'b10, 32'h2000_0010);
    step("ram_addr", 1, 0, 32'h0, 0, 32'h0);
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    HREADYOUT_RAM = 1'b0; HRDATA_RAM = 32'h0;
    step("ram_wait", 0, 0, 32'h0, 0, 32'h0);
    HREADYOUT_RAM = 1'b1; HRDATA_RAM = 32'hCAFE_F00D;
    step("ram_data", 1, 0, 32'hCAFE_F00D, 0, 32'h0);
    step("no_sel_is_def", 1, 0, 32'h0, 0, 32'h0);

    // Unmapped access
    addr_phase(0, 0, 1, 2'b10, 32'h6000_0000);
    step("unmap_addr", 1, 0, 32'h0, 0, 32'h0);
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    step("unmap_err1", 0, 1, 32'h0, 1, 32'h6000_0000);
    step("unmap_err2", 1, 1, 32'h0, 1, 32'h6000_0000);
    step("unmap_idle", 1, 0, 32'h0, 1, 32'h6000_0000);

    // Clear alone, then back-to-back errors
    ERR_CLR = 1'b1;
    step("clr_alone", 1, 0, 32'h0, 1, 32'h6000_0000);
    ERR_CLR = 1'b0;
    addr_phase(0, 0, 1, 2'b10, 32'h6000_0000);
    step("b2b_addr1", 1, 0, 32'h0, 0, 32'h6000_0000);
    addr_phase(0, 0, 1, 2'b10, 32'h7000_0004);
    step("b2b_err1a", 0, 1, 32'h0, 1, 32'h6000_0000);
    step("b2b_err2a", 1, 1, 32'h0, 1, 32'h6000_0000);
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    step("b2b_err1b", 0, 1, 32'h0, 1, 32'h6000_0000);
    step("b2b_err2b", 1, 1, 32'h0, 1, 32'h6000_0000);

    // APB error passthrough
    addr_phase(0, 1, 0, 2'b10, 32'h4000_0000);
    step("apb_addr", 1, 0, 32'h0, 1, 32'h6000_0000);
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    HREADYOUT_APB = 1'b0; HRESP_APB = 1'b1; HRDATA_APB = 32'h1234_5678;
    step("apb_err1", 0, 1, 32'h1234_5678, 1, 32'h6000_0000);
    HREADYOUT_APB = 1'b1;
    step("apb_err2", 1, 1, 32'h1234_5678, 1, 32'h6000_0000);
    HRESP_APB = 1'b0;

    // BUSY to default slave: zero-wait OKAY, no capture
    addr_phase(0, 0, 1, 2'b01, 32'h9000_0000);
    step("busy_addr", 1, 0, 32'h0, 1, 32'h6000_0000);
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    step("busy_data", 1, 0, 32'h0, 1, 32'h6000_0000);

    // Clear coinciding with a new capture
    ERR_CLR = 1'b1;
    addr_phase(0, 0, 1, 2'b10, 32'h8000_0000);
    step("clrcap_addr", 1, 0, 32'h0, 1, 32'h6000_0000);
    ERR_CLR = 1'b0;
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    step("clrcap_err1", 0, 1, 32'h0, 1, 32'h8000_0000);
    step("clrcap_err2", 1, 1, 32'h0, 1, 32'h8000_0000);

    // Asynchronous reset during a stalled RAM data phase
    addr_phase(1, 0, 0, 2'b10, 32'h2000_0020);
    step("rst_ram_addr", 1, 0, 32'h0, 1, 32'h8000_0000);
    addr_phase(0, 0, 0, 2'b00, 32'h0);
    HREADYOUT_RAM = 1'b0; HRESP_RAM = 1'b1; HRDATA_RAM = 32'h5555_AAAA;
    step("rst_ram_wait", 0, 1, 32'h5555_AAAA, 1, 32'h8000_0000);
    #2;
    HRESETn = 1'b0;
    #1;
    push(1, 0, 32'h0, 0, 32'h0);
    compare_head("rst_async");

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
